// File: rtl/iterative_muldiv_unit.sv
// Multi-cycle RV32M-style multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle. Define MULDIV_FAST_MUL_EN for a single-cycle multiplier.
module iterative_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       fn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and result/result_valid hold until the transfer.

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ALL1     = '1;
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] ZERO2  = '0;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t state;

    logic [2:0]       fn_q;
    logic             neg_q;
    logic             neg_r;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] op_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             signed_a, signed_b, sa, sb;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] special_res;

    always_comb begin
        signed_a    = (fn == 3'd1) || (fn == 3'd2) || (fn == 3'd4) || (fn == 3'd6);
        signed_b    = (fn == 3'd1) || (fn == 3'd4) || (fn == 3'd6);
        sa          = signed_a & a[WIDTH-1];
        sb          = signed_b & b[WIDTH-1];
        abs_a       = sa ? (ZERO - a) : a;
        abs_b       = sb ? (ZERO - b) : b;
        div_zero    = fn[2] && (b == ZERO);
        div_ovf     = fn[2] && !fn[0] && (a == MIN_NEG) && (b == ALL1);
        special_res = div_zero ? (fn[1] ? a : ALL1) : (fn[1] ? ZERO : a);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
    always_comb begin
        ext_a     = {{WIDTH{signed_a & a[WIDTH-1]}}, a};
        ext_b     = {{WIDTH{signed_b & b[WIDTH-1]}}, b};
        fast_prod = ext_a * ext_b;
    end
`endif

    // One iteration: multiply adds op_q into the high half then shifts right;
    // divide shifts the dividend into the partial remainder and subtracts op_q.
    logic [WIDTH:0]   sum, trial;
    logic [WIDTH-1:0] step_hi, step_lo;

    always_comb begin
        sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_q} : {1'b0, ZERO});
        trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, op_q};
        if (!fn_q[2]) begin
            step_hi = sum[WIDTH:1];
            step_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            step_hi = trial[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
            step_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s, fix_res;

    always_comb begin
        prod_s = neg_q ? (ZERO2 - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
        quo_s  = neg_q ? (ZERO - acc_lo) : acc_lo;
        rem_s  = neg_r ? (ZERO - acc_hi) : acc_hi;
        case (fn_q)
            3'd0:       fix_res = prod_s[WIDTH-1:0];
            3'd1, 3'd2,
            3'd3:       fix_res = prod_s[2*WIDTH-1:WIDTH];
            3'd4, 3'd5: fix_res = quo_s;
            default:    fix_res = rem_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            result       <= '0;
            result_valid <= 1'b0;
            fn_q         <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            count        <= '0;
            op_q         <= '0;
            acc_hi       <= '0;
            acc_lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        fn_q   <= fn;
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        count  <= '0;
                        op_q   <= fn[2] ? abs_b : abs_a;
                        acc_hi <= '0;
                        acc_lo <= fn[2] ? abs_a : abs_b;
                        if (div_zero || div_ovf) begin
                            result       <= special_res;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!fn[2]) begin
                            result       <= (fn == 3'd0) ? fast_prod[WIDTH-1:0]
                                                         : fast_prod[2*WIDTH-1:WIDTH];
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end
`endif
                        else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count + CNT_W'(1);
                    if (count == LAST) state <= FIX;
                end
                FIX: begin
                    result       <= fix_res;
                    result_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Bench for iterative_muldiv_unit (WIDTH=32): directed cases plus random ops
// against an arithmetic reference model; honours MULDIV_FAST_MUL_EN latency.
module tb_iterative_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [2:0]    fn = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [W-1:0]  result;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  iterative_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .fn(fn), .a(a), .b(b), .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // reference model: plain 64-bit arithmetic
  function automatic logic [W-1:0] ref_model(input logic [2:0] f, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    bit ovf;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    p = '0;
    case (f)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return '1;
        if (ovf) return x;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin
        if (y == 0) return '1;
        p = ux / uy; return p[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return '0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = ux % uy; return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [W-1:0] x,
                                     input logic [W-1:0] y);
    bit special;
    special = f[2] && ((y == 0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    if (special || (FAST && !f[2])) return 1;
    return W + 2;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // driver: one complete transaction with optional result back-pressure
  task automatic run_op(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int stall, input string tag);
    int lat;
    logic [W-1:0] held;
    exp_q.push_back(ref_model(f, x, y));
    @(negedge clk);
    check({tag, ".ready"}, W'(start_ready), W'(1));
    start_valid = 1'b1;
    fn = f;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    // garbage on the inputs while the unit is busy must be ignored
    start_valid = 1'($urandom_range(0, 1));
    fn = 3'($urandom);
    a = $urandom;
    b = $urandom;
    lat = 1;
    while (!result_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    start_valid = 1'b0;
    check({tag, ".latency"}, W'(lat), W'(exp_latency(f, x, y)));
    held = exp_q.pop_front();
    check({tag, ".result"}, result, held);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_result"}, result, held);
      check({tag, ".hold_valid"}, W'(result_valid), W'(1));
      check({tag, ".hold_ready"}, W'(start_ready), W'(0));
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check({tag, ".post_valid"}, W'(result_valid), W'(0));
    check({tag, ".post_ready"}, W'(start_ready), W'(1));
  endtask

  initial begin
    do_reset();
    check("reset.valid", W'(result_valid), W'(0));
    check("reset.result", result, '0);
    check("reset.ready", W'(start_ready), W'(1));
    check("reset.busy", W'(busy), W'(0));

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem_neg");
    run_op(3'd5, 32'd100, 32'd7, 0, "divu");
    run_op(3'd7, 32'd100, 32'd7, 2, "remu");
    run_op(3'd5, 32'd5, 32'd0, 0, "divu_zero");
    run_op(3'd7, 32'd5, 32'd0, 0, "remu_zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run_op(3'd4, 32'd100, 32'd7, 5, "div_stall");

    // reset in the middle of a DIV: accept at edge T, reset sampled at T+10
    @(negedge clk);
    start_valid = 1'b1;
    fn = 3'd4;
    a = 32'd1000;
    b = 32'd3;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort.busy_before", W'(busy), W'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort.valid", W'(result_valid), W'(0));
    check("abort.result", result, '0);
    check("abort.ready", W'(start_ready), W'(1));
    run_op(3'd5, 32'd9, 32'd3, 0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 2), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
